// File: rtl/serial_sub4_if.sv
// Operand/result bundle for the bit-serial 4-bit subtractor.
// The master drives the operands and start; the slave (the subtractor)
// returns status and the registered result.
interface serial_sub4_if;
   logic       start;
   logic [3:0] ain;
   logic [3:0] bin;
   logic       busy;
   logic       done;
   logic [3:0] diff;
   logic       bout;

   modport master (
      output start, ain, bin,
      input  busy, done, diff, bout
   );

   modport slave (
      input  start, ain, bin,
      output busy, done, diff, bout
   );
endinterface

// File: rtl/serial_sub4.sv
// Bit-serial 4-bit unsigned subtractor (ain - bin mod 16).
// A start in IDLE or DONE captures the operands; four CALC cycles then
// ripple the borrow LSB first. The last CALC edge loads diff/bout and
// enters DONE, so done rises exactly four edges after acceptance.
// diff/bout hold their value until the next completion or reset.
module serial_sub4 (
   input  logic         clk,
   input  logic         rst_n,
   serial_sub4_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t     state_q;
   logic [3:0] a_q;
   logic [3:0] b_q;
   logic [3:0] res_q;
   logic [3:0] diff_q;
   logic [1:0] idx_q;
   logic       br_q;
   logic       bout_q;
   logic       busy_q;
   logic       done_q;

   logic       bit_d;
   logic       br_d;
   logic [3:0] res_d;

   // Full-subtractor cell for the current LSB and the shifted partial result.
   always_comb begin
      bit_d = a_q[0] ^ b_q[0] ^ br_q;
      br_d  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
      res_d = {bit_d, res_q[3:1]};
   end

   // Control FSM and datapath registers; busy/done are registered copies of the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= 4'h0;
         b_q     <= 4'h0;
         res_q   <= 4'h0;
         diff_q  <= 4'h0;
         idx_q   <= 2'd0;
         br_q    <= 1'b0;
         bout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  a_q     <= bus.ain;
                  b_q     <= bus.bin;
                  res_q   <= 4'h0;
                  br_q    <= 1'b0;
                  idx_q   <= 2'd0;
                  state_q <= ST_CALC;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
               end else begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b0;
               end
            end
            ST_CALC: begin
               // start is deliberately not looked at here: requests in flight are dropped
               a_q   <= {1'b0, a_q[3:1]};
               b_q   <= {1'b0, b_q[3:1]};
               br_q  <= br_d;
               res_q <= res_d;
               idx_q <= idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  diff_q  <= res_d;
                  bout_q  <= br_d;
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= ST_CALC;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.diff = diff_q;
   assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_sub4.sv
// Self-checking bench for serial_sub4. A transaction-level model tracks
// "operation pending with N edges left" and computes the result with plain
// integer arithmetic; DUT outputs are sampled on the falling edge.
module tb_serial_sub4;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   // reference model state
   logic       m_busy, m_done, m_bout;
   logic [3:0] m_diff, m_a, m_b;
   int         m_cnt;

   serial_sub4_if bus();

   serial_sub4 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_busy = 1'b0; m_done = 1'b0; m_bout = 1'b0;
      m_diff = 4'h0; m_a = 4'h0; m_b = 4'h0; m_cnt = 0;
   endtask

   // Advance the model across one rising edge given the inputs sampled there.
   task automatic model_edge(input logic s, input logic [3:0] a, input logic [3:0] b);
      if (s && !m_busy) begin
         m_a = a; m_b = b; m_cnt = 4; m_busy = 1'b1; m_done = 1'b0;
      end else if (m_busy) begin
         m_cnt = m_cnt - 1;
         if (m_cnt == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
            m_diff = 4'((int'(m_a) - int'(m_b) + 16) % 16);
            m_bout = (int'(m_a) < int'(m_b));
         end
      end else begin
         m_done = 1'b0;
      end
   endtask

   // Drive inputs, cross one rising edge, return at the following falling edge.
   task automatic cycle(input logic s, input logic [3:0] a, input logic [3:0] b);
      bus.start = s; bus.ain = a; bus.bin = b;
      @(posedge clk);
      if (rst_n) model_edge(s, a, b);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.start = 1'b0; bus.ain = 4'h0; bus.bin = 4'h0;
      model_reset();
      #1;
      if ({bus.busy, bus.done, bus.diff, bus.bout} !== 7'b0) begin
         $display("FAIL reset_state got=%b exp=%b", {bus.busy, bus.done, bus.diff, bus.bout}, 7'b0);
         errors++;
      end
      checks++;
      bus.start = 1'b1; bus.ain = 4'hF; bus.bin = 4'h1;
      @(negedge clk); @(negedge clk);
      if ({bus.busy, bus.done, bus.diff, bus.bout} !== 7'b0) begin
         $display("FAIL reset_hold got=%b exp=%b", {bus.busy, bus.done, bus.diff, bus.bout}, 7'b0);
         errors++;
      end
      checks++;
      bus.start = 1'b0;
      rst_n = 1'b1;
   endtask

   // Directed operand table: basic, borrow, zero and equal operands.
   task automatic test_directed();
      logic [3:0] ta [5] = '{4'd9, 4'd3, 4'd0,  4'd0, 4'd7};
      logic [3:0] tb [5] = '{4'd4, 4'd5, 4'd15, 4'd0, 4'd7};
      logic [4:0] te [5] = '{{4'd5, 1'b0}, {4'hE, 1'b1}, {4'd1, 1'b1}, {4'd0, 1'b0}, {4'd0, 1'b0}};
      for (int t = 0; t < 5; t++) begin
         int busy_n = 0;
         int done_n = 0;
         logic [4:0] res = 5'h1F;
         cycle(1'b1, ta[t], tb[t]);
         for (int i = 0; i < 6; i++) begin
            if ({bus.busy, bus.done, bus.diff, bus.bout} !== {m_busy, m_done, m_diff, m_bout}) begin
               $display("FAIL directed_cycle t=%0d i=%0d got=%b exp=%b", t, i,
                        {bus.busy, bus.done, bus.diff, bus.bout}, {m_busy, m_done, m_diff, m_bout});
               errors++;
            end
            checks++;
            if (bus.busy) busy_n++;
            if (bus.done) begin done_n++; res = {bus.diff, bus.bout}; end
            cycle(1'b0, 4'($urandom), 4'($urandom));
         end
         if (busy_n !== 4 || done_n !== 1 || res !== te[t]) begin
            $display("FAIL directed_result a=%0d b=%0d got busy=%0d done=%0d res=%h exp busy=4 done=1 res=%h",
                     ta[t], tb[t], busy_n, done_n, res, te[t]);
            errors++;
         end
         checks++;
      end
   endtask

   task automatic test_start_during_calc();
      int done_n = 0;
      cycle(1'b1, 4'd12, 4'd2);
      cycle(1'b0, 4'd0, 4'd0);
      cycle(1'b1, 4'd1, 4'd9);
      for (int i = 0; i < 6; i++) begin
         if ({bus.busy, bus.done, bus.diff, bus.bout} !== {m_busy, m_done, m_diff, m_bout}) begin
            $display("FAIL calc_start_cycle i=%0d got=%b exp=%b", i,
                     {bus.busy, bus.done, bus.diff, bus.bout}, {m_busy, m_done, m_diff, m_bout});
            errors++;
         end
         checks++;
         if (bus.done) done_n++;
         cycle(1'b0, 4'($urandom), 4'($urandom));
      end
      if (done_n !== 1 || {bus.busy, bus.done, bus.diff, bus.bout} !== {1'b0, 1'b0, 4'd10, 1'b0}) begin
         $display("FAIL calc_start_result got done=%0d out=%b exp done=1 out=%b", done_n,
                  {bus.busy, bus.done, bus.diff, bus.bout}, {1'b0, 1'b0, 4'd10, 1'b0});
         errors++;
      end
      checks++;
   endtask

   task automatic test_back_to_back();
      int second_at = -1;
      cycle(1'b1, 4'd15, 4'd1);
      for (int i = 0; i < 4; i++) cycle(1'b0, 4'($urandom), 4'($urandom));
      if ({bus.done, bus.diff, bus.bout} !== {1'b1, 4'd14, 1'b0}) begin
         $display("FAIL b2b_first got=%b exp=%b", {bus.done, bus.diff, bus.bout}, {1'b1, 4'd14, 1'b0});
         errors++;
      end
      checks++;
      cycle(1'b1, 4'd2, 4'd3);
      for (int n = 1; n <= 6; n++) begin
         if ({bus.busy, bus.done, bus.diff, bus.bout} !== {m_busy, m_done, m_diff, m_bout}) begin
            $display("FAIL b2b_cycle n=%0d got=%b exp=%b", n,
                     {bus.busy, bus.done, bus.diff, bus.bout}, {m_busy, m_done, m_diff, m_bout});
            errors++;
         end
         checks++;
         if (bus.done && second_at < 0) begin
            second_at = n;
            if ({bus.diff, bus.bout} !== {4'hF, 1'b1}) begin
               $display("FAIL b2b_second_value got=%b exp=%b", {bus.diff, bus.bout}, {4'hF, 1'b1});
               errors++;
            end
            checks++;
         end
         cycle(1'b0, 4'($urandom), 4'($urandom));
      end
      if (second_at !== 5) begin
         $display("FAIL b2b_spacing got=%0d exp=5", second_at);
         errors++;
      end
      checks++;
   endtask

   task automatic test_reset_mid_op();
      int done_n = 0;
      logic [4:0] res = 5'h1F;
      cycle(1'b1, 4'd8, 4'd3);
      cycle(1'b0, 4'd0, 4'd0);
      cycle(1'b0, 4'd0, 4'd0);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      if ({bus.busy, bus.done, bus.diff, bus.bout} !== 7'b0) begin
         $display("FAIL reset_mid_immediate got=%b exp=%b", {bus.busy, bus.done, bus.diff, bus.bout}, 7'b0);
         errors++;
      end
      checks++;
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 4'd0, 4'd0);
         if (bus.done !== 1'b0) done_n++;
      end
      if (done_n !== 0) begin
         $display("FAIL reset_mid_no_done got=%0d exp=0", done_n);
         errors++;
      end
      checks++;
      rst_n = 1'b1;
      cycle(1'b1, 4'd8, 4'd3);
      for (int i = 0; i < 5; i++) begin
         if ({bus.busy, bus.done, bus.diff, bus.bout} !== {m_busy, m_done, m_diff, m_bout}) begin
            $display("FAIL reset_mid_fresh i=%0d got=%b exp=%b", i,
                     {bus.busy, bus.done, bus.diff, bus.bout}, {m_busy, m_done, m_diff, m_bout});
            errors++;
         end
         checks++;
         if (bus.done) res = {bus.diff, bus.bout};
         cycle(1'b0, 4'd0, 4'd0);
      end
      if (res !== {4'd5, 1'b0}) begin
         $display("FAIL reset_mid_result got=%b exp=%b", res, {4'd5, 1'b0});
         errors++;
      end
      checks++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 2) == 0), 4'($urandom), 4'($urandom));
         if ({bus.busy, bus.done, bus.diff, bus.bout} !== {m_busy, m_done, m_diff, m_bout}) begin
            $display("FAIL random_cycle i=%0d got=%b exp=%b", i,
                     {bus.busy, bus.done, bus.diff, bus.bout}, {m_busy, m_done, m_diff, m_bout});
            errors++;
         end
         checks++;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_start_during_calc();
      test_back_to_back();
      test_reset_mid_op();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/serial_sub4.md
SERIAL_SUB4 -- requirements
Module: serial_sub4

Interface
REQ-001 The module SHALL use `clk`, input, 1 bit, as its single clock; all state updates occur on the rising edge.
REQ-002 The module SHALL use `rst_n`, input, 1 bit, as an asynchronous, active-low reset.
REQ-003 The module SHALL have input `start`, 1 bit: operand-capture request.
REQ-004 The module SHALL have input `ain`, 4 bits: unsigned minuend, sampled only when `start` is accepted.
REQ-005 The module SHALL have input `bin`, 4 bits: unsigned subtrahend, sampled only when `start` is accepted.
REQ-006 The module SHALL have output `busy`, 1 bit: high while a subtraction is in progress.
REQ-007 The module SHALL have output `done`, 1 bit: single-cycle completion pulse.
REQ-008 The module SHALL have output `diff`, 4 bits, registered: the result (ain - bin) mod 16.
REQ-009 The module SHALL have output `bout`, 1 bit, registered: the final borrow, 1 iff ain < bin.

Function
REQ-010 The module SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-011 In IDLE or DONE, `start`=1 at a rising edge SHALL have these effects:
- capture `ain`/`bin` into internal shift registers;
- clear the internal borrow flop;
- set bit index to 0;
- enter CALC.
REQ-012 In CALC, each edge SHALL process one bit, LSB first:
- d = a ^ b ^ br;
- br_next = (~a & b) | (~(a ^ b) & br);
- d shifts into the result register;
- the index increments.
REQ-013 After the edge that processes bit 3, the FSM SHALL enter DONE on that same edge, and `diff`/`bout` SHALL load the final result on that same edge.
REQ-014 Latency SHALL be fixed: `start` accepted at edge k gives `done`=1 in the cycle following edge k+4, for exactly one cycle.
REQ-015 `busy` SHALL be 1 exactly while the FSM is in CALC.
REQ-016 `done` SHALL be 1 exactly while the FSM is in DONE.
REQ-017 DONE SHALL return to IDLE after one cycle if `start`=0.
REQ-018 If `start`=1 in DONE, the FSM SHALL go directly to CALC with the new operands (back-to-back operation, no idle cycle).
REQ-019 `start` asserted during CALC SHALL be ignored:
- operands are not recaptured;
- the operation in flight completes unaltered;
- no queued request is retained.
REQ-020 `diff` and `bout` SHALL change only on the completion edge (REQ-013) and on reset.
REQ-021 `diff` and `bout` SHALL hold their last result through IDLE and through any subsequent CALC until the next completion.
REQ-022 `ain`/`bin` changes outside an accepting edge SHALL have no effect.
REQ-023 Arithmetic SHALL be unsigned 4-bit modulo 16, with no overflow flag other than `bout`.
REQ-024 Equal operands SHALL yield `diff`=0 and `bout`=0.

Reset
REQ-025 Asserting `rst_n`=0 SHALL, immediately and independent of `clk`, force the following:
- FSM to IDLE;
- `busy`=0, `done`=0;
- `diff`=4'h0, `bout`=0;
- internal operand, index and borrow registers to 0.
REQ-026 Reset asserted mid-CALC SHALL abort the operation with no `done` pulse; the partial result SHALL be discarded.
REQ-027 After `rst_n` deasserts, the first rising edge with `start`=1 SHALL be accepted normally.

Verification
REQ-028 Basic subtraction: ain=9, bin=4, start pulse. Expected: `busy` high 4 cycles, then `done` 1 cycle with diff=5, bout=0.
REQ-029 Borrow case 1: ain=3, bin=5. Expected: diff=4'hE, bout=1.
REQ-030 Borrow case 2: ain=0, bin=15. Expected: diff=1, bout=1.
REQ-031 Zero and equal operands: ain=0, bin=0 gives diff=0, bout=0; ain=7, bin=7 gives diff=0, bout=0.
REQ-032 Start during CALC: start(ain=12, bin=2), then start(ain=1, bin=9) two cycles later. Expected: single `done`, diff=10, bout=0, then IDLE.
REQ-033 Back-to-back: start(15,1), then start(2,3) in the DONE cycle. Expected:
- first `done` with diff=14, bout=0;
- second `done` exactly 5 cycles later with diff=4'hF, bout=1.
REQ-034 Reset mid-op: start(8,3), `rst_n`=0 after 2 cycles. Expected: outputs 0 immediately, no `done`; a fresh start(8,3) then yields diff=5, bout=0.
